// File: rtl/cap_wbuf_pkg.sv
// cap_wbuf_pkg: shared types and helpers for the capability-aware write buffer.
//   wbuf_state_t : per-entry lifecycle FREE -> VALID -> ISSUED -> FREE.
//   word_shift() : number of byte-offset bits stripped to form a word index.
// The entry struct depends on module parameters, so it is declared in cap_wbuf.
package cap_wbuf_pkg;

  typedef enum logic [1:0] {
    WB_FREE   = 2'd0,
    WB_VALID  = 2'd1,
    WB_ISSUED = 2'd2
  } wbuf_state_t;

  // Byte-offset bits inside one buffer word (word index = addr >> word_shift).
  function automatic int unsigned word_shift(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/cap_wbuf_match.sv
// cap_wbuf_match: address compare over all entries with youngest-first select.
// Ports:
//   key   : word-aligned address to look up.
//   addrs : word-aligned address of each entry.
//   cand  : entries allowed to match (state filter supplied by the caller).
//   base  : tail pointer; the youngest entry is base-1, the oldest is base.
//   hit   : some candidate entry matches key.
//   idx   : index of the youngest matching entry (0 when no hit).
module cap_wbuf_match #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic [ADDR_WIDTH-1:0]            key,
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addrs,
  input  logic [DEPTH-1:0]                 cand,
  input  logic [PTR_W-1:0]                 base,
  output logic                             hit,
  output logic [PTR_W-1:0]                 idx
);

  logic [PTR_W-1:0] pos_s;

  // Walk from oldest (base) to youngest (base-1); later matches overwrite
  // earlier ones, so the youngest match wins.
  always_comb begin
    hit   = 1'b0;
    idx   = '0;
    pos_s = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      pos_s = base - PTR_W'(k);
      if (cand[pos_s] && (addrs[pos_s] == key)) begin
        hit = 1'b1;
        idx = pos_s;
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/cap_wbuf.sv
// cap_wbuf: capability-aware store write buffer between the store unit and the
// cache/memory write port, with load forwarding and a CHERI tag side-band.
// Optional feature macro: CAP_WBUF_MERGE_EN (byte-merging of stores into a
// not-yet-issued entry of the same word). Without it every push allocates.
// Ports:
//   clk_i, rst_ni                 : clock, asynchronous active-low reset.
//   push_*                        : store request (valid/ready, addr, data, be, tag).
//   mem_req_*                     : write request of the oldest VALID entry.
//   mem_ack_i                     : in-order completion of the oldest ISSUED write.
//   ld_addr_i / ld_*              : load lookup, youngest VALID/ISSUED match.
//   empty_o                       : no entries in use.
module cap_wbuf
  import cap_wbuf_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_valid_i,
  output logic                    push_ready_o,
  input  logic [ADDR_WIDTH-1:0]   push_addr_i,
  input  logic [DATA_WIDTH-1:0]   push_data_i,
  input  logic [DATA_WIDTH/8-1:0] push_be_i,
  input  logic [TAG_WIDTH-1:0]    push_tag_i,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_req_data_o,
  output logic [DATA_WIDTH/8-1:0] mem_req_be_o,
  output logic [TAG_WIDTH-1:0]    mem_req_tag_o,
  input  logic                    mem_ack_i,
  input  logic [ADDR_WIDTH-1:0]   ld_addr_i,
  output logic                    ld_hit_o,
  output logic [DATA_WIDTH-1:0]   ld_data_o,
  output logic [DATA_WIDTH/8-1:0] ld_be_o,
  output logic [TAG_WIDTH-1:0]    ld_tag_o,
  output logic                    empty_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF   = int'(word_shift(DATA_WIDTH));
  localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF) - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_W-1:0]       be;
    logic [TAG_WIDTH-1:0]  tag;
    wbuf_state_t           state;
  } entry_t;

  entry_t           ent_r [DEPTH];
  logic [PTR_W-1:0] tail_r, issue_r, head_r;
  logic [CNT_W-1:0] count_r;

  logic [ADDR_WIDTH-1:0]            push_word_s, ld_word_s;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addrs_s;
  logic [DEPTH-1:0]                 fwd_cand_s;
  logic                             merge_hit_s, fwd_hit_s;
  logic [PTR_W-1:0]                 merge_idx_s, fwd_idx_s;
  logic                             issue_fire_s, ack_fire_s, push_fire_s, alloc_s;
  logic [TAG_WIDTH-1:0]             new_tag_s;
  logic [DATA_WIDTH-1:0]            merged_data_s;

  assign push_word_s = push_addr_i & ~OFF_MASK;
  assign ld_word_s   = ld_addr_i & ~OFF_MASK;

  assign issue_fire_s = (ent_r[issue_r].state == WB_VALID) && mem_req_ready_i;
  // An ack is only honoured when there really is an outstanding write.
  assign ack_fire_s   = mem_ack_i && (ent_r[head_r].state == WB_ISSUED);
  assign push_ready_o = merge_hit_s || (count_r < DEPTH_C);
  assign push_fire_s  = push_valid_i && push_ready_o;
  assign alloc_s      = push_fire_s && !merge_hit_s;
  // A partial write cannot carry a valid capability.
  assign new_tag_s    = (&push_be_i) ? push_tag_i : '0;

  // Flatten entry addresses and forwarding candidates for the matchers.
  always_comb begin
    addrs_s    = '0;
    fwd_cand_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      addrs_s[i]    = ent_r[i].addr;
      fwd_cand_s[i] = (ent_r[i].state != WB_FREE);
    end
  end

`ifdef CAP_WBUF_MERGE_EN
  logic [DEPTH-1:0] merge_cand_s;

  // Merge targets are VALID entries, except the one handed to memory this cycle.
  always_comb begin
    merge_cand_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      merge_cand_s[i] = (ent_r[i].state == WB_VALID) &&
                        !(issue_fire_s && (issue_r == PTR_W'(i)));
    end
  end

  cap_wbuf_match #(
    .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) u_merge (
    .key(push_word_s), .addrs(addrs_s), .cand(merge_cand_s), .base(tail_r),
    .hit(merge_hit_s), .idx(merge_idx_s)
  );
`else
  assign merge_hit_s = 1'b0;
  assign merge_idx_s = '0;
`endif

  cap_wbuf_match #(
    .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fwd (
    .key(ld_word_s), .addrs(addrs_s), .cand(fwd_cand_s), .base(tail_r),
    .hit(fwd_hit_s), .idx(fwd_idx_s)
  );

  // Byte-wise overlay of the incoming store onto the merge target.
  always_comb begin
    merged_data_s = '0;
    for (int b = 0; b < BE_W; b++) begin
      if (push_be_i[b]) begin
        merged_data_s[b*8 +: 8] = push_data_i[b*8 +: 8];
      end else begin
        merged_data_s[b*8 +: 8] = ent_r[merge_idx_s].data[b*8 +: 8];
      end
    end
  end

  // Memory request always presents the entry at the issue pointer.
  assign mem_req_valid_o = (ent_r[issue_r].state == WB_VALID);
  assign mem_req_addr_o  = ent_r[issue_r].addr;
  assign mem_req_data_o  = ent_r[issue_r].data;
  assign mem_req_be_o    = ent_r[issue_r].be;
  assign mem_req_tag_o   = ent_r[issue_r].tag;
  assign empty_o         = (count_r == '0);

  // Load forwarding outputs are zero when nothing matches.
  always_comb begin
    ld_hit_o  = fwd_hit_s;
    ld_data_o = '0;
    ld_be_o   = '0;
    ld_tag_o  = '0;
    if (fwd_hit_s) begin
      ld_data_o = ent_r[fwd_idx_s].data;
      ld_be_o   = ent_r[fwd_idx_s].be;
      ld_tag_o  = ent_r[fwd_idx_s].tag;
    end else begin
      ld_hit_o  = 1'b0;
    end
  end

  // Entry state, pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i] <= '0;
      end
      tail_r  <= '0;
      issue_r <= '0;
      head_r  <= '0;
      count_r <= '0;
    end else begin
      if (issue_fire_s) begin
        ent_r[issue_r].state <= WB_ISSUED;
        issue_r              <= issue_r + PTR_W'(1);
      end
      if (ack_fire_s) begin
        ent_r[head_r].state <= WB_FREE;
        head_r              <= head_r + PTR_W'(1);
      end
      if (push_fire_s && merge_hit_s) begin
        ent_r[merge_idx_s].data <= merged_data_s;
        ent_r[merge_idx_s].be   <= ent_r[merge_idx_s].be | push_be_i;
        ent_r[merge_idx_s].tag  <= new_tag_s;
      end
      if (alloc_s) begin
        ent_r[tail_r].addr  <= push_word_s;
        ent_r[tail_r].data  <= push_data_i;
        ent_r[tail_r].be    <= push_be_i;
        ent_r[tail_r].tag   <= new_tag_s;
        ent_r[tail_r].state <= WB_VALID;
        tail_r              <= tail_r + PTR_W'(1);
      end
      case ({alloc_s, ack_fire_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_cap_wbuf.sv
// tb_cap_wbuf: directed self-checking bench for cap_wbuf (DEPTH=4, 64-bit).
// Expected values track the CAP_WBUF_MERGE_EN build option.
module tb_cap_wbuf;

  localparam int DEPTH = 4;
  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int BW    = DW / 8;
  localparam int TW    = 1;
`ifdef CAP_WBUF_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif
  // Number of entries produced by two same-word stores.
  localparam int N2 = MERGE ? 1 : 2;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          push_valid_i, push_ready_o;
  logic [AW-1:0] push_addr_i;
  logic [DW-1:0] push_data_i;
  logic [BW-1:0] push_be_i;
  logic [TW-1:0] push_tag_i;
  logic          mem_req_valid_o, mem_req_ready_i;
  logic [AW-1:0] mem_req_addr_o;
  logic [DW-1:0] mem_req_data_o;
  logic [BW-1:0] mem_req_be_o;
  logic [TW-1:0] mem_req_tag_o;
  logic          mem_ack_i;
  logic [AW-1:0] ld_addr_i;
  logic          ld_hit_o;
  logic [DW-1:0] ld_data_o;
  logic [BW-1:0] ld_be_o;
  logic [TW-1:0] ld_tag_o;
  logic          empty_o;

  int passed = 0;
  int total  = 0;

  cap_wbuf #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_addr_i(push_addr_i), .push_data_i(push_data_i),
    .push_be_i(push_be_i), .push_tag_i(push_tag_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
    .mem_req_be_o(mem_req_be_o), .mem_req_tag_o(mem_req_tag_o),
    .mem_ack_i(mem_ack_i), .ld_addr_i(ld_addr_i), .ld_hit_o(ld_hit_o),
    .ld_data_o(ld_data_o), .ld_be_o(ld_be_o), .ld_tag_o(ld_tag_o),
    .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one store for exactly one clock edge.
  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [BW-1:0] be, input logic [TW-1:0] t);
    push_addr_i  = a;
    push_data_i  = d;
    push_be_i    = be;
    push_tag_i   = t;
    push_valid_i = 1'b1;
    tick();
    push_valid_i = 1'b0;
  endtask

  // Issue n entries, acknowledge n writes, expect an empty buffer.
  task automatic drain(input int n, input string tag);
    mem_req_ready_i = 1'b1;
    repeat (n) tick();
    mem_req_ready_i = 1'b0;
    #1 chk({tag, "_req_idle"}, mem_req_valid_o, 1'b0);
    mem_ack_i = 1'b1;
    repeat (n) tick();
    mem_ack_i = 1'b0;
    #1 chk({tag, "_empty"}, empty_o, 1'b1);
  endtask

  initial begin
    rst_ni = 1'b0;
    push_valid_i = 1'b0; push_addr_i = '0; push_data_i = '0;
    push_be_i = '0; push_tag_i = '0;
    mem_req_ready_i = 1'b0; mem_ack_i = 1'b0; ld_addr_i = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", empty_o, 1'b1);
    chk("rst_push_ready", push_ready_o, 1'b1);
    chk("rst_req_valid", mem_req_valid_o, 1'b0);
    chk("rst_ld_hit", ld_hit_o, 1'b0);
    chk("rst_ld_data", ld_data_o, 64'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();

    // 1: full-word capability store, issue, ack
    push_addr_i = 64'h8000_0000; push_data_i = 64'hDEAD_BEEF_CAFE_F00D;
    push_be_i = 8'hFF; push_tag_i = 1'b1; push_valid_i = 1'b1;
    #1 chk("t1_same_cycle_req", mem_req_valid_o, 1'b0);
    tick();
    push_valid_i = 1'b0;
    #1;
    chk("t1_req_valid", mem_req_valid_o, 1'b1);
    chk("t1_req_addr", mem_req_addr_o, 64'h8000_0000);
    chk("t1_req_data", mem_req_data_o, 64'hDEAD_BEEF_CAFE_F00D);
    chk("t1_req_tag", mem_req_tag_o, 1'b1);
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    ld_addr_i = 64'h8000_0004;
    #1;
    chk("t1_issued_not_empty", empty_o, 1'b0);
    chk("t1_fwd_issued_hit", ld_hit_o, 1'b1);
    chk("t1_req_idle", mem_req_valid_o, 1'b0);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    #1 chk("t1_empty", empty_o, 1'b1);

    // 2: partial stores to one word with memory stalled
    push(64'h1000, 64'h0000_0000_1111_1111, 8'h0F, 1'b1);
    push(64'h1004, 64'h2222_2222_0000_0000, 8'hF0, 1'b1);
    ld_addr_i = 64'h1000;
    #1;
    chk("t2_req_data", mem_req_data_o, MERGE ? 64'h2222_2222_1111_1111 : 64'h0000_0000_1111_1111);
    chk("t2_req_be", mem_req_be_o, MERGE ? 8'hFF : 8'h0F);
    chk("t2_req_tag", mem_req_tag_o, 1'b0);
    chk("t2_ld_data", ld_data_o, MERGE ? 64'h2222_2222_1111_1111 : 64'h2222_2222_0000_0000);
    chk("t2_ld_be", ld_be_o, MERGE ? 8'hFF : 8'hF0);
    chk("t2_ld_tag", ld_tag_o, 1'b0);
    drain(N2, "t2");
    chk("t2_ld_miss", ld_hit_o, 1'b0);
    chk("t2_ld_miss_data", ld_data_o, 64'h0);

    // 3: capability store followed by a byte store before issue
    push(64'h3000, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
    push(64'h3000, 64'h0000_0000_0000_00AB, 8'h01, 1'b1);
    ld_addr_i = 64'h3000;
    #1;
    chk("t3_req_tag", mem_req_tag_o, MERGE ? 1'b0 : 1'b1);
    chk("t3_req_data", mem_req_data_o, MERGE ? 64'h0123_4567_89AB_CDAB : 64'h0123_4567_89AB_CDEF);
    chk("t3_ld_tag", ld_tag_o, 1'b0);
    chk("t3_ld_data", ld_data_o, MERGE ? 64'h0123_4567_89AB_CDAB : 64'h0000_0000_0000_00AB);
    drain(N2, "t3");

    // 4: fill all entries, full backpressure, ack does not free same-cycle space
    for (int i = 0; i < DEPTH; i++) begin
      push(64'h4000 + 64'(8 * i), 64'(i + 1), 8'hFF, 1'b0);
    end
    push_addr_i = 64'h4020; push_be_i = 8'hFF; push_valid_i = 1'b1;
    #1 chk("t4_full_new", push_ready_o, 1'b0);
    push_addr_i = 64'h4008;
    #1 chk("t4_full_match", push_ready_o, MERGE ? 1'b1 : 1'b0);
    push_valid_i = 1'b0;
    chk("t4_req_addr0", mem_req_addr_o, 64'h4000);
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    push_addr_i = 64'h4020; push_data_i = 64'h55; push_valid_i = 1'b1;
    mem_ack_i = 1'b1;
    #1 chk("t4_ack_stall", push_ready_o, 1'b0);
    tick();
    mem_ack_i = 1'b0;
    #1 chk("t4_after_ack_ready", push_ready_o, 1'b1);
    tick();
    push_valid_i = 1'b0;
    ld_addr_i = 64'h4020;
    #1;
    chk("t4_fwd_new", ld_hit_o, 1'b1);
    chk("t4_fwd_new_data", ld_data_o, 64'h55);
    chk("t4_full_again", push_ready_o, 1'b0);
    chk("t4_req_addr1", mem_req_addr_o, 64'h4008);
    drain(DEPTH, "t4");

    // 5: same word pushed again after issue -> youngest forwarded
    push(64'h2000, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b0);
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    push(64'h2000, 64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, 1'b0);
    ld_addr_i = 64'h2000;
    #1;
    chk("t5_ld_hit", ld_hit_o, 1'b1);
    chk("t5_ld_data", ld_data_o, 64'hBBBB_BBBB_BBBB_BBBB);
    chk("t5_second_entry", mem_req_valid_o, 1'b1);
    chk("t5_second_data", mem_req_data_o, 64'hBBBB_BBBB_BBBB_BBBB);

    // 6: reset with three outstanding writes, stray ack afterwards
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    push(64'h2008, 64'hC, 8'hFF, 1'b0);
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    #1;
    chk("t6_busy", empty_o, 1'b0);
    #1 rst_ni = 1'b0;
    #1;
    chk("t6_rst_empty", empty_o, 1'b1);
    chk("t6_rst_ld_hit", ld_hit_o, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    #1;
    chk("t6_stray_ack_empty", empty_o, 1'b1);
    chk("t6_stray_ack_ready", push_ready_o, 1'b1);
    push(64'h5000, 64'h5, 8'hFF, 1'b0);
    #1;
    chk("t6_post_req_valid", mem_req_valid_o, 1'b1);
    chk("t6_post_req_addr", mem_req_addr_o, 64'h5000);
    drain(1, "t6");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Safety net: the directed sequence is far shorter than this.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
